// File: rtl/pump_sequencer_if.sv
// Signal bundle between the pump sequencer and its ADC front end, the threshold controller and the supervisor.
// ADC handshake: adc_req is raised by the sequencer and held until a cycle with adc_ack high
// (adc_data is captured in that cycle) or until the ack timeout; adc_ack while adc_req is low is ignored.
interface pump_sequencer_if;
  logic       adc_req;
  logic       adc_ack;
  logic [7:0] adc_data;
  logic [7:0] tsgh;
  logic       sample_vld;
  logic       pump_req;
  logic       fault_clr;
  logic       pump_en;
  logic       fault;
  logic [1:0] fault_code;
  logic       samp_state;
  logic [1:0] pump_state;

  modport master (
    output adc_req, tsgh, sample_vld, pump_en, fault, fault_code, samp_state, pump_state,
    input  adc_ack, adc_data, pump_req, fault_clr
  );

  modport slave (
    input  adc_req, tsgh, sample_vld, pump_en, fault, fault_code, samp_state, pump_state,
    output adc_ack, adc_data, pump_req, fault_clr
  );
endinterface

// File: rtl/pump_sequencer.sv
// Periodic ADC sampler plus pump on/off/fault sequencer with dwell times, run limit and ADC timeout.
module pump_sequencer #(
  parameter int SAMPLE_DIV = 1000,
  parameter int ADC_TO     = 255,
  parameter int MIN_ON     = 16,
  parameter int MIN_OFF    = 16,
  parameter int MAX_RUN    = 240
) (
  input  logic              clk,
  input  logic              rst,
  pump_sequencer_if.master  bus
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [7:0] TO_LAST   = 8'(ADC_TO - 1);
  localparam logic [7:0] MIN_ON_C  = 8'(MIN_ON);
  localparam logic [7:0] MIN_OFF_C = 8'(MIN_OFF);
  localparam logic [7:0] MAX_RUN_C = 8'(MAX_RUN);

  typedef enum logic {S_WAIT = 1'b0, S_REQ = 1'b1} samp_t;
  typedef enum logic [1:0] {P_OFF = 2'd0, P_ON = 2'd1, P_FAULT = 2'd2} pump_t;

  samp_t            samp_q, samp_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       to_q, to_d;
  logic             req_q, req_d;
  logic [7:0]       tsgh_q, tsgh_d;
  logic             vld_q, vld_d;
  logic             timeout;

  pump_t            pump_q, pump_d;
  logic [7:0]       dwell_q, dwell_d, dwell_inc;
  logic [1:0]       code_q, code_d;
  logic             pen_q, fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q  <= S_WAIT;
      div_q   <= '0;
      to_q    <= '0;
      req_q   <= 1'b0;
      tsgh_q  <= '0;
      vld_q   <= 1'b0;
      pump_q  <= P_OFF;
      dwell_q <= '0;
      code_q  <= 2'd0;
      pen_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      samp_q  <= samp_d;
      div_q   <= div_d;
      to_q    <= to_d;
      req_q   <= req_d;
      tsgh_q  <= tsgh_d;
      vld_q   <= vld_d;
      pump_q  <= pump_d;
      dwell_q <= dwell_d;
      code_q  <= code_d;
      pen_q   <= (pump_d == P_ON);
      fault_q <= (pump_d == P_FAULT);
    end
  end

  // Sampler: divider runs only in WAIT; an ack on the final timeout clock still counts as a sample.
  always_comb begin
    samp_d  = samp_q;
    div_d   = div_q;
    to_d    = to_q;
    req_d   = req_q;
    tsgh_d  = tsgh_q;
    vld_d   = 1'b0;
    timeout = 1'b0;
    case (samp_q)
      S_WAIT: begin
        if (div_q == DIV_LAST) begin
          samp_d = S_REQ;
          req_d  = 1'b1;
          to_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_REQ: begin
        if (bus.adc_ack) begin
          tsgh_d = bus.adc_data;
          vld_d  = 1'b1;
          req_d  = 1'b0;
          div_d  = '0;
          samp_d = S_WAIT;
        end else if (to_q == TO_LAST) begin
          timeout = 1'b1;
          req_d   = 1'b0;
          div_d   = '0;
          samp_d  = S_WAIT;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      default: samp_d = S_WAIT;
    endcase
  end

  assign dwell_inc = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;

  // Pump: decisions only on sample_vld cycles, except timeout (any cycle) and fault_clr (level).
  always_comb begin
    pump_d  = pump_q;
    dwell_d = dwell_q;
    code_d  = code_q;
    if (timeout) begin
      pump_d  = P_FAULT;
      code_d  = 2'd2;
      dwell_d = '0;
    end else begin
      case (pump_q)
        P_OFF: begin
          if (vld_q) begin
            if (bus.pump_req && dwell_q >= MIN_OFF_C) begin
              pump_d  = P_ON;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_inc;
            end
          end
        end
        P_ON: begin
          if (vld_q) begin
            if (dwell_q >= MAX_RUN_C) begin
              pump_d  = P_FAULT;
              code_d  = 2'd1;
              dwell_d = '0;
            end else if (!bus.pump_req && dwell_q >= MIN_ON_C) begin
              pump_d  = P_OFF;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_inc;
            end
          end
        end
        P_FAULT: begin
          if (bus.fault_clr) begin
            pump_d  = P_OFF;
            code_d  = 2'd0;
            dwell_d = '0;
          end else if (vld_q) begin
            dwell_d = dwell_inc;
          end
        end
        default: begin
          pump_d  = P_OFF;
          dwell_d = '0;
        end
      endcase
    end
  end

  assign bus.adc_req    = req_q;
  assign bus.tsgh       = tsgh_q;
  assign bus.sample_vld = vld_q;
  assign bus.pump_en    = pen_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;
  assign bus.samp_state = samp_q;
  assign bus.pump_state = pump_q;

endmodule

// File: tb/tb_pump_sequencer.sv
// Directed bench for pump_sequencer: sample timing, dwell rules, overrun, ADC timeout and reset cases.
module tb_pump_sequencer;
  localparam int SAMPLE_DIV = 4;
  localparam int ADC_TO     = 8;
  localparam int MIN_ON     = 2;
  localparam int MIN_OFF    = 2;
  localparam int MAX_RUN    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_tsgh;

  pump_sequencer_if bus();

  pump_sequencer #(
    .SAMPLE_DIV(SAMPLE_DIV), .ADC_TO(ADC_TO), .MIN_ON(MIN_ON),
    .MIN_OFF(MIN_OFF), .MAX_RUN(MAX_RUN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every sample_vld must match the oldest acked adc_data.
  always @(negedge clk) begin
    if (bus.sample_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("vld_without_ack", bus.sample_vld, 1'b0);
      end else begin
        exp_tsgh = exp_q.pop_front();
        check("tsgh_on_vld", bus.tsgh, exp_tsgh);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.adc_ack = 1'b0;
    bus.fault_clr = 1'b0;
    bus.pump_req = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    while (bus.adc_req !== 1'b1 && lat < 40) begin
      tick(1);
      lat++;
    end
    if (bus.adc_req !== 1'b1) check("adc_req_never_rose", bus.adc_req, 1'b1);
  endtask

  // Acks one clock after adc_req; returns at the clock after the sample_vld cycle.
  task automatic sample(input logic [7:0] d, input logic pr, output int lat, output logic pen_vld);
    bus.pump_req = pr;
    wait_req(lat);
    bus.adc_ack = 1'b1;
    bus.adc_data = d;
    exp_q.push_back(d);
    tick(1);
    bus.adc_ack = 1'b0;
    bus.adc_data = 8'($urandom_range(0, 255));
    check("req_drop_on_ack", bus.adc_req, 1'b0);
    check("vld_pulse", bus.sample_vld, 1'b1);
    pen_vld = bus.pump_en;
    tick(1);
    check("vld_one_cycle", bus.sample_vld, 1'b0);
  endtask

  // Lets a request time out; optionally pulses fault_clr on the timeout clock.
  task automatic no_ack(input logic clr_at_to, output int high_cnt, output int lat);
    wait_req(lat);
    high_cnt = 0;
    while (bus.adc_req === 1'b1 && high_cnt < 40) begin
      if (clr_at_to && high_cnt == ADC_TO - 1) bus.fault_clr = 1'b1;
      tick(1);
      bus.fault_clr = 1'b0;
      high_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int hc;
    logic pv;
    bus.adc_ack = 1'b0;
    bus.adc_data = 8'h00;
    bus.pump_req = 1'b0;
    bus.fault_clr = 1'b0;

    // Reset values
    tick(3);
    check("rst_adc_req", bus.adc_req, 1'b0);
    check("rst_tsgh", bus.tsgh, 8'h00);
    check("rst_vld", bus.sample_vld, 1'b0);
    check("rst_pump_en", bus.pump_en, 1'b0);
    check("rst_fault", bus.fault, 1'b0);
    check("rst_code", bus.fault_code, 2'd0);
    check("rst_samp_state", bus.samp_state, 1'b0);
    check("rst_pump_state", bus.pump_state, 2'd0);

    // Sample timing: req on clock 4 after reset, then 4 clocks after each ack
    do_reset();
    sample(8'h55, 1'b0, lat, pv);
    check("t1_first_req_latency", lat, 4);
    check("t1_tsgh", bus.tsgh, 8'h55);
    sample(8'h55, 1'b0, lat, pv);
    check("t1_req_after_ack", lat, SAMPLE_DIV - 1);

    // OFF dwell: pump_en rises after the 3rd sample with pump_req held
    do_reset();
    sample(8'h10, 1'b1, lat, pv);
    check("t2_s1_pen", bus.pump_en, 1'b0);
    sample(8'h11, 1'b1, lat, pv);
    check("t2_s2_pen", bus.pump_en, 1'b0);
    sample(8'h12, 1'b1, lat, pv);
    check("t2_s3_pen_during_vld", pv, 1'b0);
    check("t2_s3_pen", bus.pump_en, 1'b1);

    // ON dwell: early drop of pump_req is held until dwell reaches MIN_ON
    sample(8'h20, 1'b1, lat, pv);
    check("t3_s4_pen", bus.pump_en, 1'b1);
    sample(8'h21, 1'b0, lat, pv);
    check("t3_s5_pen_hold", bus.pump_en, 1'b1);
    sample(8'h22, 1'b0, lat, pv);
    check("t3_s6_pen_during_vld", pv, 1'b1);
    check("t3_s6_pen_off", bus.pump_en, 1'b0);

    // Overrun, code overwrite by timeout, then clear and restart
    do_reset();
    for (int i = 0; i < 3; i++) sample(8'(8'h30 + i), 1'b1, lat, pv);
    check("t4_on", bus.pump_en, 1'b1);
    for (int i = 0; i < MAX_RUN; i++) begin
      sample(8'(8'h40 + i), 1'b1, lat, pv);
      check("t4_run_pen", bus.pump_en, 1'b1);
      check("t4_run_fault", bus.fault, 1'b0);
    end
    sample(8'h4F, 1'b1, lat, pv);
    check("t4_ovr_fault", bus.fault, 1'b1);
    check("t4_ovr_code", bus.fault_code, 2'd1);
    check("t4_ovr_pen", bus.pump_en, 1'b0);
    no_ack(1'b0, hc, lat);
    check("t4_to_in_fault_code", bus.fault_code, 2'd2);
    check("t4_to_in_fault_flag", bus.fault, 1'b1);
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    check("t4_clr_fault", bus.fault, 1'b0);
    check("t4_clr_code", bus.fault_code, 2'd0);
    check("t4_clr_pen", bus.pump_en, 1'b0);
    sample(8'h50, 1'b1, lat, pv);
    check("t4_re_s1_pen", bus.pump_en, 1'b0);
    sample(8'h51, 1'b1, lat, pv);
    check("t4_re_s2_pen", bus.pump_en, 1'b0);
    sample(8'h52, 1'b1, lat, pv);
    check("t4_re_s3_pen", bus.pump_en, 1'b1);

    // ADC timeout from ON
    do_reset();
    sample(8'h61, 1'b1, lat, pv);
    sample(8'h62, 1'b1, lat, pv);
    sample(8'hA3, 1'b1, lat, pv);
    check("t5_on", bus.pump_en, 1'b1);
    no_ack(1'b0, hc, lat);
    check("t5_req_high_clocks", hc, ADC_TO);
    check("t5_fault", bus.fault, 1'b1);
    check("t5_code", bus.fault_code, 2'd2);
    check("t5_pen", bus.pump_en, 1'b0);
    check("t5_tsgh_kept", bus.tsgh, 8'hA3);
    // Timeout again with fault_clr on the same clock: fault must win
    no_ack(1'b1, hc, lat);
    check("t5_next_req_latency", lat, SAMPLE_DIV);
    check("t6_clr_vs_to_fault", bus.fault, 1'b1);
    check("t6_clr_vs_to_code", bus.fault_code, 2'd2);

    // Reset during a request, late ack ignored
    do_reset();
    sample(8'h00, 1'b0, lat, pv);
    exp_q.delete();
    wait_req(lat);
    rst = 1'b1;
    tick(1);
    check("t6_req_drop_on_rst", bus.adc_req, 1'b0);
    rst = 1'b0;
    bus.adc_ack = 1'b1;
    bus.adc_data = 8'h77;
    tick(1);
    bus.adc_ack = 1'b0;
    check("t6_post_rst_req", bus.adc_req, 1'b0);
    check("t6_post_rst_tsgh", bus.tsgh, 8'h00);
    check("t6_post_rst_vld", bus.sample_vld, 1'b0);
    check("t6_post_rst_fault", bus.fault, 1'b0);
    check("t6_post_rst_code", bus.fault_code, 2'd0);
    check("t6_post_rst_pen", bus.pump_en, 1'b0);
    tick(2);
    check("t6_late_ack_tsgh", bus.tsgh, 8'h00);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
